// File: rtl/selector_campo_programacion_if.sv
// ============================================================================
// Module : selector_campo_programacion_if
// Brief  : Front-panel buttons, programming enable and field-select outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface selector_campo_programacion_if;
    logic       en_prog;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic [3:0] en_count;
    logic       enUP;
    logic       enDOWN;
    logic       campo_cambio;

    modport master (
        output en_prog, btn_up, btn_down, btn_left, btn_right,
        input  en_count, enUP, enDOWN, campo_cambio
    );

    modport slave (
        input  en_prog, btn_up, btn_down, btn_left, btn_right,
        output en_count, enUP, enDOWN, campo_cambio
    );
endinterface

`default_nettype wire

// File: rtl/selector_campo_programacion.sv
// ============================================================================
// Module : selector_campo_programacion
// Brief  : Button conditioning and field-select FSM for programming mode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module selector_campo_programacion #(
    parameter int N_CAMPOS   = 9,
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_BITS   = 20          // 2**DEB_BITS must exceed DEB_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset,
    selector_campo_programacion_if.slave bus
);

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    localparam logic [DEB_BITS-1:0] DEB_LAST  = DEB_BITS'(DEB_CYCLES - 1);
    localparam logic [DEB_BITS-1:0] DEB_ONE   = DEB_BITS'(1);
    localparam logic [3:0]          CAMPO_MIN = 4'd1;
    localparam logic [3:0]          CAMPO_MAX = 4'(N_CAMPOS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PROG = 1'b1
    } state_t;

    logic [3:0] raw;
    logic [3:0] deb;
    logic [3:0] deb_prev;
    logic       pulse_left;
    logic       pulse_right;

    assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic                meta;
            logic                sync_q;
            logic                stable;
            logic [DEB_BITS-1:0] cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    meta   <= 1'b0;
                    sync_q <= 1'b0;
                end else begin
                    meta   <= raw[gi];
                    sync_q <= meta;
                end
            end

            // Any return to the accepted level restarts the stability window.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stable <= 1'b0;
                    cnt    <= '0;
                end else if (sync_q == stable) begin
                    cnt    <= '0;
                end else if (cnt == DEB_LAST) begin
                    stable <= sync_q;
                    cnt    <= '0;
                end else begin
                    cnt    <= cnt + DEB_ONE;
                end
            end

            assign deb[gi] = stable;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_prev <= '0;
        end else begin
            deb_prev <= deb;
        end
    end

    assign pulse_left  = deb[BTN_LEFT]  & ~deb_prev[BTN_LEFT];
    assign pulse_right = deb[BTN_RIGHT] & ~deb_prev[BTN_RIGHT];

    state_t     state;
    state_t     state_next;
    logic [3:0] en_count;
    logic [3:0] en_count_next;
    logic       campo_cambio;
    logic       en_up;
    logic       en_down;
    logic       en_up_next;
    logic       en_down_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            en_count     <= '0;
            campo_cambio <= 1'b0;
            en_up        <= 1'b0;
            en_down      <= 1'b0;
        end else begin
            state        <= state_next;
            en_count     <= en_count_next;
            campo_cambio <= (en_count_next != en_count);
            en_up        <= en_up_next;
            en_down      <= en_down_next;
        end
    end

    always_comb begin
        state_next    = state;
        en_count_next = en_count;
        case (state)
            IDLE: begin
                en_count_next = '0;
                if (bus.en_prog) begin
                    state_next    = PROG;
                    en_count_next = CAMPO_MIN;
                end
            end
            PROG: begin
                if (!bus.en_prog) begin
                    state_next    = IDLE;
                    en_count_next = '0;
                end else if (pulse_right && !pulse_left) begin
                    en_count_next = (en_count >= CAMPO_MAX || en_count < CAMPO_MIN)
                                  ? CAMPO_MIN : en_count + 4'd1;
                end else if (pulse_left && !pulse_right) begin
                    en_count_next = (en_count <= CAMPO_MIN || en_count > CAMPO_MAX)
                                  ? CAMPO_MAX : en_count - 4'd1;
                end else if (en_count < CAMPO_MIN || en_count > CAMPO_MAX) begin
                    en_count_next = CAMPO_MIN;
                end
            end
            default: begin
                state_next    = IDLE;
                en_count_next = '0;
            end
        endcase
    end

    // Up and down cancel each other so a downstream counter never sees both.
    always_comb begin
        en_up_next   = (state == PROG) & bus.en_prog & deb[BTN_UP]   & ~deb[BTN_DOWN];
        en_down_next = (state == PROG) & bus.en_prog & deb[BTN_DOWN] & ~deb[BTN_UP];
    end

    assign bus.en_count     = en_count;
    assign bus.enUP         = en_up;
    assign bus.enDOWN       = en_down;
    assign bus.campo_cambio = campo_cambio;

endmodule

`default_nettype wire

// File: tb/tb_selector_campo_programacion.sv
// ============================================================================
// Module : tb_selector_campo_programacion
// Brief  : Scoreboarded bench for the programming-mode field selector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_selector_campo_programacion;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   sb[$];

    selector_campo_programacion_if bus ();

    selector_campo_programacion #(
        .N_CAMPOS  (9),
        .DEB_CYCLES(4),
        .DEB_BITS  (4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            BTN_UP:    bus.btn_up    = v;
            BTN_DOWN:  bus.btn_down  = v;
            BTN_LEFT:  bus.btn_left  = v;
            default:   bus.btn_right = v;
        endcase
    endtask

    task automatic press(input int which, input int hold, input int after);
        set_btn(which, 1'b1);
        step(hold);
        set_btn(which, 1'b0);
        step(after);
    endtask

    // Every field change must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.campo_cambio) begin
            if (sb.size() == 0) begin
                check("spurious_cambio", bus.campo_cambio, 0);
            end else begin
                check("sb_en_count", bus.en_count, sb.pop_front());
            end
        end
        if (!reset && (bus.enUP || bus.enDOWN)) begin
            check("up_down_excl", bus.enUP & bus.enDOWN, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        reset         = 1'b1;
        bus.en_prog   = 1'b0;
        bus.btn_up    = 1'b0;
        bus.btn_down  = 1'b0;
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        step(3);
        check("rst_en_count", bus.en_count, 0);
        check("rst_enUP", bus.enUP, 0);
        check("rst_enDOWN", bus.enDOWN, 0);
        check("rst_cambio", bus.campo_cambio, 0);
        reset = 1'b0;
        step(2);

        // Enter programming mode.
        bus.en_prog = 1'b1;
        sb.push_back(1);
        step(1);
        check("enter_en_count", bus.en_count, 1);
        check("enter_cambio", bus.campo_cambio, 1);
        check("enter_enUP", bus.enUP, 0);
        check("enter_enDOWN", bus.enDOWN, 0);
        step(1);
        check("enter_cambio_once", bus.campo_cambio, 0);

        // 1 -> 9 by left wrap, then 9 -> 1 by right wrap with latency check.
        sb.push_back(9);
        press(BTN_LEFT, 10, 10);
        check("left_wrap", bus.en_count, 9);
        sb.push_back(1);
        bus.btn_right = 1'b1;
        step(6);
        check("right_latency_pre", bus.en_count, 9);
        step(1);
        check("right_wrap", bus.en_count, 1);
        step(3);
        bus.btn_right = 1'b0;
        step(10);
        check("right_once", bus.en_count, 1);
        sb.push_back(9);
        press(BTN_LEFT, 10, 10);
        sb.push_back(8);
        press(BTN_LEFT, 10, 10);
        check("left_twice", bus.en_count, 8);

        // Glitches shorter than the debounce window.
        for (int g = 1; g <= 3; g++) begin
            press(BTN_RIGHT, g, 10);
            check($sformatf("glitch_%0d", g), bus.en_count, 8);
        end

        // Up held alone, then overlapped with down.
        bus.btn_up = 1'b1;
        step(6);
        check("up_pre", bus.enUP, 0);
        step(1);
        check("up_on", bus.enUP, 1);
        check("up_down_off", bus.enDOWN, 0);
        step(13);
        bus.btn_up = 1'b0;
        step(6);
        check("up_hold_after_rel", bus.enUP, 1);
        step(1);
        check("up_off", bus.enUP, 0);
        step(5);
        bus.btn_up = 1'b1;
        step(10);
        check("ovl_up_on", bus.enUP, 1);
        bus.btn_down = 1'b1;
        step(7);
        check("ovl_up", bus.enUP, 0);
        check("ovl_down", bus.enDOWN, 0);
        step(5);
        bus.btn_up = 1'b0;
        step(7);
        check("down_on", bus.enDOWN, 1);
        check("down_up_off", bus.enUP, 0);
        bus.btn_down = 1'b0;
        step(10);
        check("down_off", bus.enDOWN, 0);

        // Simultaneous left and right cancel.
        bus.btn_left  = 1'b1;
        bus.btn_right = 1'b1;
        step(10);
        bus.btn_left  = 1'b0;
        bus.btn_right = 1'b0;
        step(10);
        check("both_lr", bus.en_count, 8);

        // Leaving programming mode wins over a pending right step.
        bus.btn_right = 1'b1;
        step(6);
        bus.en_prog = 1'b0;
        sb.push_back(0);
        step(1);
        check("exit_priority", bus.en_count, 0);
        check("exit_enUP", bus.enUP, 0);
        check("exit_enDOWN", bus.enDOWN, 0);
        bus.btn_right = 1'b0;
        step(10);

        // Walk to field 7, hold up, then reset mid-operation.
        bus.en_prog = 1'b1;
        sb.push_back(1);
        step(2);
        for (int k = 9; k >= 7; k--) begin
            sb.push_back(k);
            press(BTN_LEFT, 10, 10);
        end
        check("field7", bus.en_count, 7);
        bus.btn_up = 1'b1;
        step(10);
        check("pre_rst_up", bus.enUP, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_en_count", bus.en_count, 0);
        check("async_rst_enUP", bus.enUP, 0);
        check("async_rst_enDOWN", bus.enDOWN, 0);
        check("async_rst_cambio", bus.campo_cambio, 0);
        step(3);
        reset = 1'b0;
        sb.push_back(1);
        step(1);
        check("post_rst_en_count", bus.en_count, 1);
        check("post_rst_up0", bus.enUP, 0);
        step(5);
        check("post_rst_up_pre", bus.enUP, 0);
        step(1);
        check("post_rst_up_on", bus.enUP, 1);

        bus.btn_up  = 1'b0;
        bus.en_prog = 1'b0;
        sb.push_back(0);
        step(3);
        check("final_en_count", bus.en_count, 0);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
